pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, PC value loaded on reset.
REQ-002 Parameter TRAP_STALL, default 8'h01, exception code treated as non-fatal.
REQ-003 Parameter DRAIN_CYCLES, default 2, cycles between halt detection and assertion of done.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-005 clk  in  1  pipeline clock.
REQ-006 rst  in  1  async active-high reset.
REQ-007 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-008 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs or rt.
REQ-009 ex_rd  in  5  destination register of the instruction in EX.
REQ-010 ex_mem2reg  in  1  EX instruction is a load.
REQ-011 im_stall  in  1  instruction memory requests a one-cycle fetch hold.
REQ-012 br_enable  in  1  branch resolved taken in EX.
REQ-013 br_target  in  32  branch destination address.
REQ-014 wb_exception  in  8  exception code leaving WB.
REQ-015 pc_id  out  32  address of the instruction entering ID.
REQ-016 id_hold  out  1  freeze the ID register (no new IR latched).
REQ-017 ex_bubble  out  1  inject a NOP into EX (clear reg/mem write enables).
REQ-018 br_trigger  out  1  the ID instruction is a flushed wrong-path slot.
REQ-019 halted  out  1  pipeline stopped due to a fatal exception.
REQ-020 done  out  1  drain complete; the testbench may finish.
REQ-021 cycle_count  out  64  cycles since reset release.
REQ-022 stall_count  out  32  cycles in which pc_id did not advance while in RUN.

Function
REQ-023 FSM states: RUN, LSTALL, HALT, DONE; reset state is RUN.
REQ-024 Load-use hazard = ex_mem2reg & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-025 Fatal = wb_exception!=0 & wb_exception!=TRAP_STALL.
REQ-026 Priority per cycle in RUN: fatal > br_enable > load-use > im_stall > advance.
REQ-027 Fatal in RUN or LSTALL: next state HALT, pc_id frozen, ex_bubble=1 combinationally, halted=1 registered from the next edge.
REQ-028 br_enable in RUN: pc_id<=br_target, br_trigger<=1 for exactly one cycle, no stall counted.
REQ-029 Load-use in RUN with no branch: id_hold=1 and ex_bubble=1 combinationally; pc_id held; next state LSTALL; stall_count+1.
REQ-030 LSTALL lasts exactly one cycle: id_hold=0, ex_bubble=0, pc_id<=pc_id+4, return to RUN; a load-use condition re-detected in LSTALL SHALL NOT extend the stall.
REQ-031 br_enable in LSTALL SHALL take effect as in REQ-028 (the branch wins over the +4).
REQ-032 im_stall only (RUN): pc_id held, id_hold=1, ex_bubble=0, br_trigger<=0, stall_count+1.
REQ-033 Advance: pc_id<=pc_id+4 (modulo 2^32 wrap), br_trigger<=0.
REQ-034 HALT: outputs frozen except a drain counter, which counts DRAIN_CYCLES edges, then DONE; done=1 in DONE, sticky until reset.
REQ-035 cycle_count increments every edge in every state except DONE; stall_count saturates at 32'hFFFFFFFF.
REQ-036 br_target bits [1:0] are not checked; the value is loaded verbatim.

Reset
REQ-037 rst high SHALL immediately (asynchronously) force pc_id=RESET_PC, state RUN, br_trigger=0, halted=0, done=0, cycle_count=0, stall_count=0, drain counter=0.
REQ-038 Combinational outputs id_hold and ex_bubble SHALL be 0 while rst is high.
REQ-039 rst asserted mid-LSTALL or mid-HALT SHALL abandon the state with no residual stall or bubble after release.

Verification
REQ-040 Straight-line run: 4 edges after reset -> pc_id=0x3010, cycle_count=4, stall_count=0.
REQ-041 Load-use: ex_mem2reg=1, ex_rd=8, id_rs=8, id_uses_rs=1 at pc_id=0x3004 -> id_hold=ex_bubble=1 for one cycle; pc_id 0x3004 then 0x3008; stall_count=1.
REQ-042 Load with ex_rd=0 against id_rs=0 -> no stall; pc_id advances.
REQ-043 br_enable=1 with br_target=0x3040, coincident with load-use -> pc_id=0x3040, br_trigger=1 for one cycle, stall_count unchanged.
REQ-044 wb_exception=TRAP_STALL -> no halt; wb_exception=8'h04 -> halted=1 next edge, done=1 exactly DRAIN_CYCLES edges later, pc_id frozen.
REQ-045 Assert rst asynchronously between edges during HALT -> outputs take reset values without a clock edge; normal run resumes from 0x3000.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control for a 5-stage in-order core.
//
// Tracks the PC of the instruction entering ID. Detects load-use hazards
// (one-cycle stall plus bubble), taken branches (redirect plus flush
// marker), instruction-memory fetch holds and fatal exceptions leaving WB
// (halt, drain, then done).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   id_rs, id_rt        source registers of the ID instruction
//   id_uses_rs/rt       ID instruction actually reads rs / rt
//   ex_rd, ex_mem2reg   destination and load flag of the EX instruction
//   im_stall            instruction memory asks for a one-cycle hold
//   br_enable/target    taken branch resolved in EX and its destination
//   wb_exception        exception code leaving WB (0 = none)
//   pc_id               PC of the instruction entering ID
//   id_hold, ex_bubble  combinational freeze of ID / NOP injection into EX
//   br_trigger          ID slot is a flushed wrong-path instruction
//   halted, done        fatal stop seen / drain finished (sticky)
//   cycle_count         edges since reset release (stops in DONE)
//   stall_count         RUN cycles where pc_id did not advance (saturating)

module pipe_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_3000,
   parameter logic [7:0]  TRAP_STALL   = 8'h01,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem2reg,
   input  logic        im_stall,
   input  logic        br_enable,
   input  logic [31:0] br_target,
   input  logic [7:0]  wb_exception,
   output logic [31:0] pc_id,
   output logic        id_hold,
   output logic        ex_bubble,
   output logic        br_trigger,
   output logic        halted,
   output logic        done,
   output logic [63:0] cycle_count,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {S_RUN, S_LSTALL, S_HALT, S_DONE} state_t;

   // Last drain count value before moving to DONE; DRAIN_CYCLES of 0 or 1
   // both leave HALT on its first edge.
   localparam logic [15:0] DRAIN_LAST =
      (DRAIN_CYCLES > 1) ? 16'(DRAIN_CYCLES - 1) : 16'd0;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        br_trig_q, br_trig_d;
   logic        halted_q, halted_d;
   logic        done_q, done_d;
   logic [15:0] drain_q, drain_d;
   logic [63:0] cyc_q, cyc_d;
   logic [31:0] stall_q, stall_d;

   logic load_use, fatal, stall_inc, hold, bubble;

   assign load_use = ex_mem2reg && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));
   assign fatal    = (wb_exception != 8'd0) && (wb_exception != TRAP_STALL);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      br_trig_d = br_trig_q;
      halted_d  = halted_q;
      done_d    = done_q;
      drain_d   = drain_q;
      stall_inc = 1'b0;
      hold      = 1'b0;
      bubble    = 1'b0;
      cyc_d     = (state_q == S_DONE) ? cyc_q : cyc_q + 64'd1;

      case (state_q)
         S_RUN: begin
            if (fatal) begin
               state_d   = S_HALT;
               halted_d  = 1'b1;
               bubble    = 1'b1;
               br_trig_d = 1'b0;
            end else if (br_enable) begin
               // Branch beats the hazard: the hazarding ID instruction is
               // on the wrong path anyway.
               pc_d      = br_target;
               br_trig_d = 1'b1;
            end else if (load_use) begin
               hold      = 1'b1;
               bubble    = 1'b1;
               stall_inc = 1'b1;
               br_trig_d = 1'b0;
               state_d   = S_LSTALL;
            end else if (im_stall) begin
               hold      = 1'b1;
               stall_inc = 1'b1;
               br_trig_d = 1'b0;
            end else begin
               pc_d      = pc_q + 32'd4;
               br_trig_d = 1'b0;
            end
         end
         S_LSTALL: begin
            // Exactly one cycle; a hazard still visible here is the same
            // load, now resolved by forwarding, so it is ignored.
            if (fatal) begin
               state_d   = S_HALT;
               halted_d  = 1'b1;
               bubble    = 1'b1;
               br_trig_d = 1'b0;
            end else if (br_enable) begin
               pc_d      = br_target;
               br_trig_d = 1'b1;
               state_d   = S_RUN;
            end else begin
               pc_d      = pc_q + 32'd4;
               br_trig_d = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_HALT: begin
            hold   = 1'b1;
            bubble = 1'b1;
            if (drain_q >= DRAIN_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 16'd1;
            end
         end
         default: begin
            hold   = 1'b1;
            bubble = 1'b1;
         end
      endcase

      stall_d = (stall_inc && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1
                                                          : stall_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RUN;
         pc_q      <= RESET_PC;
         br_trig_q <= 1'b0;
         halted_q  <= 1'b0;
         done_q    <= 1'b0;
         drain_q   <= 16'd0;
         cyc_q     <= 64'd0;
         stall_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         br_trig_q <= br_trig_d;
         halted_q  <= halted_d;
         done_q    <= done_d;
         drain_q   <= drain_d;
         cyc_q     <= cyc_d;
         stall_q   <= stall_d;
      end
   end

   // Combinational controls are forced low during reset so the pipeline
   // never sees a stale stall or bubble around reset.
   assign id_hold     = hold & ~rst;
   assign ex_bubble   = bubble & ~rst;
   assign pc_id       = pc_q;
   assign br_trigger  = br_trig_q;
   assign halted      = halted_q;
   assign done        = done_q;
   assign cycle_count = cyc_q;
   assign stall_count = stall_q;

endmodule
